ipr_nvme_cq_doorbell: RTL and testbench
=======================================

Name: ipr_nvme_cq_doorbell

Overview:
Downstream stage of the NVMe completion-queue state machine. Accepts the admin-CQ and IO-CQ head-update handshakes (head_done/head_ack plus a 16-bit head index) and writes the new head value to the controller's CQ head doorbell register over an AXI4-Lite write master. It arbitrates between the two queues, performs one doorbell write at a time, and counts successful writes and failed responses.

Parameters:
DB_BASE, 32'h0000_1000, byte address of the doorbell region (BAR0 offset 0x1000).
DSTRD, 4, doorbell stride CAP.DSTRD; stride in bytes = 4 << DSTRD.
IO_QID, 1, queue ID of the IO completion queue.
RESP_TIMEOUT, 16'd1023, maximum cycles to wait for the B response.

Ports:
clk_in  in  1  clock
resetb  in  1  asynchronous active-low reset
acq_head_done  in  1  admin CQ head update pending; held until acked
acq_head_local_out  in  16  new admin CQ head index
acq_head_done_ack  out  1  one-cycle accept pulse for the admin request
iocq_head_done  in  1  IO CQ head update pending; held until acked
iocq_head_local_out  in  16  new IO CQ head index
iocq_head_done_ack  out  1  one-cycle accept pulse for the IO request
m_awaddr  out  32  doorbell address
m_awvalid  out  1  AXI-Lite AW valid
m_awready  in  1  AXI-Lite AW ready
m_wdata  out  32  {16'd0, head}
m_wstrb  out  4  always 4'hF
m_wvalid  out  1  AXI-Lite W valid
m_wready  in  1  AXI-Lite W ready
m_bresp  in  2  write response
m_bvalid  in  1  B valid
m_bready  out  1  B ready
db_write_cnt  out  32  doorbell writes completed with OKAY
db_err_cnt  out  16  writes completed with bresp != 2'b00
db_timeout  out  1  sticky; set when B response times out

Behaviour:
- Reset (resetb low, asynchronous): state=S_IDLE; all outputs 0; both counters 0; arbiter pointer favours admin.
- Address rule: admin (qid 0) = DB_BASE + (4<<DSTRD); IO = DB_BASE + (2*IO_QID+1)*(4<<DSTRD). Computed with 32-bit unsigned arithmetic, constant per queue.
- States: S_IDLE, S_WRITE, S_RESP, S_ERR.
- S_IDLE: if exactly one done is high, that request is selected. If both are high, round-robin selection: serve the queue not served last; after reset, admin wins. In the cycle of selection, the module pulses the matching *_ack for one cycle, latches the head into m_wdata[15:0] and the address into m_awaddr, asserts m_awvalid and m_wvalid, and moves to S_WRITE. The loser remains pending, with no ack.
- No ack is issued in any state other than S_IDLE. Acks are never issued while done is low.
- S_WRITE: m_awvalid drops on the cycle after awvalid&awready; m_wvalid drops on the cycle after wvalid&wready. AW and W complete independently, in either order or in the same cycle. When both have completed, the module asserts m_bready and moves to S_RESP. m_awaddr and m_wdata are stable while their valid is high.
- S_RESP: on m_bvalid&m_bready, m_bready drops. If bresp==0, db_write_cnt increments; otherwise db_err_cnt increments, saturating at 16'hFFFF. The state then returns to S_IDLE. Both counters wrap/saturate only as stated.
- Timeout: a 16-bit counter runs in S_WRITE and S_RESP and clears in S_IDLE. When it reaches RESP_TIMEOUT, db_timeout is set, all valids and bready deassert, and the state moves to S_ERR.
- S_ERR: terminal. No further acks are issued and no AXI traffic occurs. The only exit is reset.
- Latency: done high in S_IDLE gives ack on the next edge, with awvalid/wvalid asserting on the same edge. With an always-ready slave and bvalid one cycle after W, the cycle from done back to S_IDLE is 4 cycles.
- Back-to-back requests: minimum one S_IDLE cycle between writes.
- Reset mid-transaction: valids drop immediately. Any pending done is re-served after reset.

Decomposition:
- Shared package ipr_nvme_pkg: state encodings (one-hot 4-bit, matching the CQ state machine style), AXI_RESP_OKAY, doorbell offset 0x1000, admin QID 0.
- No sub-module is needed. The AXI-Lite write channel logic is small enough to stay inline.

Test Plan:
- Admin request alone, with acq_head_local_out=16'h0005, DSTRD=0, and an always-ready slave -> AW 32'h1004, W 32'h0000_0005, one ack pulse, db_write_cnt=1.
- IO request alone, with head 16'h003F, IO_QID=1, DSTRD=0 -> AW 32'h100C, W 32'h0000_003F, iocq ack one pulse.
- Both done high at the same time after reset -> admin is served first, then IO. Issuing both again -> IO served first (round-robin).
- awready is delayed 3 cycles while wready is immediate, and bresp=2'b10 -> no duplicate W, db_err_cnt=1, db_write_cnt unchanged, next request still served.
- bvalid never asserted, RESP_TIMEOUT=8 -> db_timeout=1 eight cycles after entering S_WRITE, a later done gets no ack, and resetb low clears the error.
- resetb pulsed low while awvalid is high -> awvalid=0 asynchronously. The pending done is served once resetb returns high.

Source files
------------

// File: rtl/ipr_nvme_pkg.sv
// Shared definitions for the NVMe completion-queue doorbell path: FSM encoding,
// AXI response codes and the doorbell address helper.
package ipr_nvme_pkg;

  typedef enum logic [3:0] {
    StIdle  = 4'b0001,
    StWrite = 4'b0010,
    StResp  = 4'b0100,
    StErr   = 4'b1000
  } db_state_e;

  localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
  localparam logic [31:0] DB_OFFSET     = 32'h0000_1000;
  localparam int unsigned ADMIN_QID     = 0;

  // CQ head doorbell of queue qid sits at slot 2*qid+1; slot size is 4 << DSTRD bytes.
  function automatic logic [31:0] db_addr(input logic [31:0]  base,
                                          input int unsigned  qid,
                                          input int unsigned  dstrd);
    logic [31:0] stride;
    stride = 32'd4 << dstrd;
    return base + (32'(2 * qid + 1) * stride);
  endfunction

endpackage

// File: rtl/ipr_nvme_cq_doorbell.sv
// Writes admin/IO completion-queue head updates to the controller CQ head doorbells
// over an AXI4-Lite write master, one write at a time, with round-robin arbitration.
module ipr_nvme_cq_doorbell
  import ipr_nvme_pkg::*;
#(
  parameter logic [31:0] DB_BASE      = DB_OFFSET,
  parameter int unsigned DSTRD        = 4,
  parameter int unsigned IO_QID       = 1,
  parameter logic [15:0] RESP_TIMEOUT = 16'd1023
) (
  input  logic        clk_in,
  input  logic        resetb,
  input  logic        acq_head_done,
  input  logic [15:0] acq_head_local_out,
  output logic        acq_head_done_ack,
  input  logic        iocq_head_done,
  input  logic [15:0] iocq_head_local_out,
  output logic        iocq_head_done_ack,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] db_write_cnt,
  output logic [15:0] db_err_cnt,
  output logic        db_timeout
);

  localparam logic [31:0] AcqAddr = db_addr(DB_BASE, ADMIN_QID, DSTRD);
  localparam logic [31:0] IoAddr  = db_addr(DB_BASE, IO_QID, DSTRD);

  db_state_e   state_q;
  logic        acq_ack_q, io_ack_q;
  logic [31:0] awaddr_q;
  logic [15:0] head_q;
  logic        awvalid_q, wvalid_q, bready_q;
  logic [31:0] wr_cnt_q;
  logic [15:0] err_cnt_q;
  logic        timeout_q;
  logic        last_io_q;
  logic [15:0] tmo_q;

  logic        sel_acq, sel_io;
  logic        aw_hs, w_hs, aw_done, w_done;
  logic [15:0] tmo_inc;
  logic        tmo_hit;

  // last_io_q resets high so admin wins the first tie.
  assign sel_acq = acq_head_done & (~iocq_head_done | last_io_q);
  assign sel_io  = iocq_head_done & (~acq_head_done | ~last_io_q);

  assign aw_hs   = awvalid_q & m_awready;
  assign w_hs    = wvalid_q & m_wready;
  assign aw_done = ~awvalid_q | m_awready;
  assign w_done  = ~wvalid_q | m_wready;

  assign tmo_inc = tmo_q + 16'd1;
  assign tmo_hit = (tmo_inc == RESP_TIMEOUT);

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      state_q   <= StIdle;
      acq_ack_q <= 1'b0;
      io_ack_q  <= 1'b0;
      awaddr_q  <= '0;
      head_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
      timeout_q <= 1'b0;
      last_io_q <= 1'b1;
      tmo_q     <= '0;
    end else begin
      acq_ack_q <= 1'b0;
      io_ack_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          tmo_q <= '0;
          if (sel_acq || sel_io) begin
            acq_ack_q <= sel_acq;
            io_ack_q  <= sel_io;
            awaddr_q  <= sel_acq ? AcqAddr : IoAddr;
            head_q    <= sel_acq ? acq_head_local_out : iocq_head_local_out;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            last_io_q <= sel_io;
            state_q   <= StWrite;
          end
        end
        StWrite: begin
          tmo_q <= tmo_inc;
          if (tmo_hit) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= StErr;
          end else begin
            if (aw_hs) awvalid_q <= 1'b0;
            if (w_hs)  wvalid_q  <= 1'b0;
            if (aw_done && w_done) begin
              bready_q <= 1'b1;
              state_q  <= StResp;
            end
          end
        end
        StResp: begin
          tmo_q <= tmo_inc;
          if (tmo_hit) begin
            bready_q  <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= StErr;
          end else if (m_bvalid) begin
            bready_q <= 1'b0;
            if (m_bresp == AXI_RESP_OKAY) begin
              wr_cnt_q <= wr_cnt_q + 32'd1;
            end else if (err_cnt_q != 16'hFFFF) begin
              err_cnt_q <= err_cnt_q + 16'd1;
            end
            state_q <= StIdle;
          end
        end
        StErr: begin
          // Terminal until reset; outputs already parked low.
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign acq_head_done_ack  = acq_ack_q;
  assign iocq_head_done_ack = io_ack_q;
  assign m_awaddr           = awaddr_q;
  assign m_awvalid          = awvalid_q;
  assign m_wdata            = {16'd0, head_q};
  assign m_wstrb            = 4'hF;
  assign m_wvalid           = wvalid_q;
  assign m_bready           = bready_q;
  assign db_write_cnt       = wr_cnt_q;
  assign db_err_cnt         = err_cnt_q;
  assign db_timeout         = timeout_q;

endmodule

// File: tb/tb_ipr_nvme_cq_doorbell.sv
// Directed bench for ipr_nvme_cq_doorbell: AXI-Lite slave model plus a scoreboard of
// expected doorbell writes, pushed when a head update is raised and popped on handshake.
module tb_ipr_nvme_cq_doorbell;

  logic        clk_in = 1'b0;
  logic        resetb = 1'b0;
  logic        acq_done = 1'b0, iocq_done = 1'b0;
  logic [15:0] acq_head = '0, iocq_head = '0;
  logic        acq_ack, iocq_ack;
  logic [31:0] m_awaddr, m_wdata;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp;
  logic [31:0] db_write_cnt;
  logic [15:0] db_err_cnt;
  logic        db_timeout;

  ipr_nvme_cq_doorbell #(
    .DB_BASE      (32'h0000_1000),
    .DSTRD        (0),
    .IO_QID       (1),
    .RESP_TIMEOUT (16'd8)
  ) dut (
    .clk_in              (clk_in),
    .resetb              (resetb),
    .acq_head_done       (acq_done),
    .acq_head_local_out  (acq_head),
    .acq_head_done_ack   (acq_ack),
    .iocq_head_done      (iocq_done),
    .iocq_head_local_out (iocq_head),
    .iocq_head_done_ack  (iocq_ack),
    .m_awaddr            (m_awaddr),
    .m_awvalid           (m_awvalid),
    .m_awready           (m_awready),
    .m_wdata             (m_wdata),
    .m_wstrb             (m_wstrb),
    .m_wvalid            (m_wvalid),
    .m_wready            (m_wready),
    .m_bresp             (m_bresp),
    .m_bvalid            (m_bvalid),
    .m_bready            (m_bready),
    .db_write_cnt        (db_write_cnt),
    .db_err_cnt          (db_err_cnt),
    .db_timeout          (db_timeout)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          aw_delay = 0, w_delay = 0, aw_wait = 0, w_wait = 0;
  logic [1:0]  b_resp_cfg = 2'b00;
  bit          b_enable = 1'b1;
  bit          aw_seen = 1'b0, w_seen = 1'b0;
  int          acq_ack_cnt = 0, io_ack_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Slave model and write monitor; readies are decided at the falling edge so the
  // handshakes recorded here are the ones the DUT sees on the next rising edge.
  initial begin
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;
    m_bresp   = 2'b00;
    forever begin
      @(negedge clk_in);
      if (m_awvalid) begin
        m_awready = (aw_wait >= aw_delay);
        aw_wait++;
      end else begin
        m_awready = 1'b0;
        aw_wait   = 0;
      end
      if (m_wvalid) begin
        m_wready = (w_wait >= w_delay);
        w_wait++;
      end else begin
        m_wready = 1'b0;
        w_wait   = 0;
      end
      m_bvalid = b_enable && m_bready;
      m_bresp  = b_resp_cfg;
      if (m_awvalid && m_awready) begin
        chk("aw_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("aw_addr", m_awaddr, exp_q[0].addr);
        chk("aw_dup", 32'(aw_seen), 32'd0);
        aw_seen = 1'b1;
      end
      if (m_wvalid && m_wready) begin
        chk("w_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("w_data", m_wdata, exp_q[0].data);
        chk("w_strb", 32'(m_wstrb), 32'hF);
        chk("w_dup", 32'(w_seen), 32'd0);
        w_seen = 1'b1;
      end
      if (aw_seen && w_seen) begin
        void'(exp_q.pop_front());
        aw_seen = 1'b0;
        w_seen  = 1'b0;
      end
      if (acq_ack) acq_ack_cnt++;
      if (iocq_ack) io_ack_cnt++;
    end
  end

  task automatic req(input bit io, input logic [15:0] head);
    exp_t e;
    e.addr = io ? 32'h0000_100C : 32'h0000_1004;
    e.data = {16'h0000, head};
    exp_q.push_back(e);
    if (io) begin
      iocq_head = head;
      iocq_done = 1'b1;
    end else begin
      acq_head = head;
      acq_done = 1'b1;
    end
  endtask

  task automatic wait_ack(input bit io, input bit drop, input string tag, output int lat);
    bit ga, gi;
    ga  = 1'b0;
    gi  = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk_in);
      if (acq_ack || iocq_ack) begin
        ga  = acq_ack;
        gi  = iocq_ack;
        lat = n;
        break;
      end
    end
    chk({tag, "_ack"}, 32'({gi, ga}), io ? 32'd2 : 32'd1);
    chk({tag, "_valids"}, 32'({m_awvalid, m_wvalid}), 32'd3);
    if (drop) begin
      if (ga) acq_done = 1'b0;
      if (gi) iocq_done = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk_in);
      if (exp_q.size() == 0 && !m_awvalid && !m_wvalid && !m_bready) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_idle"}, 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    resetb = 1'b0;
    repeat (2) @(negedge clk_in);
    resetb = 1'b1;
  endtask

  initial begin
    int lat, a0, i0, exp_wr, exp_err;

    // Reset state
    repeat (2) @(negedge clk_in);
    chk("rst_awvalid", 32'(m_awvalid), 32'd0);
    chk("rst_wvalid", 32'(m_wvalid), 32'd0);
    chk("rst_bready", 32'(m_bready), 32'd0);
    chk("rst_acks", 32'({acq_ack, iocq_ack}), 32'd0);
    chk("rst_wr_cnt", db_write_cnt, 32'd0);
    chk("rst_err_cnt", 32'(db_err_cnt), 32'd0);
    chk("rst_timeout", 32'(db_timeout), 32'd0);
    chk("rst_awaddr", m_awaddr, 32'd0);
    resetb = 1'b1;
    exp_wr = 0;
    exp_err = 0;

    // Admin alone
    @(negedge clk_in);
    a0 = acq_ack_cnt;
    req(1'b0, 16'h0005);
    wait_ack(1'b0, 1'b1, "adm", lat);
    chk("adm_latency", 32'(lat), 32'd1);
    wait_idle("adm");
    exp_wr++;
    chk("adm_ack_pulses", 32'(acq_ack_cnt - a0), 32'd1);
    chk("adm_wr_cnt", db_write_cnt, 32'(exp_wr));

    // IO alone
    i0 = io_ack_cnt;
    req(1'b1, 16'h003F);
    wait_ack(1'b1, 1'b1, "io", lat);
    wait_idle("io");
    exp_wr++;
    chk("io_ack_pulses", 32'(io_ack_cnt - i0), 32'd1);
    chk("io_wr_cnt", db_write_cnt, 32'(exp_wr));

    // Both pending after reset: admin, then IO, then the re-raised admin
    do_reset();
    exp_wr = 0;
    req(1'b0, 16'h00A1);
    req(1'b1, 16'h00B2);
    wait_ack(1'b0, 1'b1, "rr1", lat);
    req(1'b0, 16'h00C3);
    wait_ack(1'b1, 1'b1, "rr2", lat);
    wait_ack(1'b0, 1'b1, "rr3", lat);
    wait_idle("rr");
    exp_wr += 3;
    chk("rr_wr_cnt", db_write_cnt, 32'(exp_wr));

    // Slow AW, fast W, SLVERR response
    aw_delay = 3;
    b_resp_cfg = 2'b10;
    req(1'b0, 16'h0077);
    wait_ack(1'b0, 1'b1, "slv", lat);
    wait_idle("slv");
    exp_err++;
    chk("slv_err_cnt", 32'(db_err_cnt), 32'(exp_err));
    chk("slv_wr_cnt", db_write_cnt, 32'(exp_wr));
    aw_delay = 0;
    b_resp_cfg = 2'b00;
    req(1'b1, 16'h0012);
    wait_ack(1'b1, 1'b1, "post_err", lat);
    wait_idle("post_err");
    exp_wr++;
    chk("post_err_wr_cnt", db_write_cnt, 32'(exp_wr));

    // B never arrives: timeout after 8 cycles, then no service until reset
    b_enable = 1'b0;
    req(1'b0, 16'h0009);
    wait_ack(1'b0, 1'b1, "tmo", lat);
    repeat (7) @(negedge clk_in);
    chk("tmo_before", 32'(db_timeout), 32'd0);
    @(negedge clk_in);
    chk("tmo_set", 32'(db_timeout), 32'd1);
    chk("tmo_outs", 32'({m_awvalid, m_wvalid, m_bready}), 32'd0);
    i0 = io_ack_cnt;
    req(1'b1, 16'h0055);
    repeat (10) @(negedge clk_in);
    chk("tmo_no_ack", 32'(io_ack_cnt - i0), 32'd0);
    chk("tmo_no_aw", 32'(m_awvalid), 32'd0);
    resetb = 1'b0;
    #1;
    chk("tmo_cleared", 32'(db_timeout), 32'd0);
    @(negedge clk_in);
    resetb = 1'b1;
    b_enable = 1'b1;
    wait_ack(1'b1, 1'b1, "tmo_rec", lat);
    wait_idle("tmo_rec");
    chk("tmo_rec_wr_cnt", db_write_cnt, 32'd1);

    // Reset while AW is outstanding; the held request is served again
    aw_delay = 5;
    w_delay = 5;
    a0 = acq_ack_cnt;
    req(1'b0, 16'h0044);
    wait_ack(1'b0, 1'b0, "mid", lat);
    #2;
    resetb = 1'b0;
    #1;
    chk("mid_rst_valids", 32'({m_awvalid, m_wvalid}), 32'd0);
    @(negedge clk_in);
    aw_delay = 0;
    w_delay = 0;
    resetb = 1'b1;
    wait_ack(1'b0, 1'b1, "mid_re", lat);
    wait_idle("mid_re");
    chk("mid_ack_pulses", 32'(acq_ack_cnt - a0), 32'd2);
    chk("mid_wr_cnt", db_write_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no completion expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
